// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with fill count, almost-full/empty thresholds,
// standard or first-word-fall-through read mode and sticky overflow/underflow flags.
module sync_fifo_param #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned AF_LEVEL   = 12,
    parameter int unsigned AE_LEVEL   = 4,
    parameter bit          FWFT       = 1'b0
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  wr_en_i,
    input  logic [DATA_WIDTH-1:0] data_in_i,
    input  logic                  rd_en_i,
    input  logic                  clr_err_i,
    output logic [DATA_WIDTH-1:0] data_out_o,
    output logic                  wr_full_o,
    output logic                  rd_empty_o,
    output logic                  almost_full_o,
    output logic                  almost_empty_o,
    output logic [ADDR_WIDTH:0]   count_o,
    output logic                  overflow_o,
    output logic                  underflow_o
);

    localparam int unsigned Depth = 2 ** ADDR_WIDTH;

    typedef logic [ADDR_WIDTH:0] cnt_t;

    localparam cnt_t DepthCnt = cnt_t'(Depth);
    localparam cnt_t AfCnt    = cnt_t'(AF_LEVEL);
    localparam cnt_t AeCnt    = cnt_t'(AE_LEVEL);

    logic [DATA_WIDTH-1:0] mem_q [Depth];

    cnt_t wr_ptr_q, wr_ptr_d;
    cnt_t rd_ptr_q, rd_ptr_d;
    cnt_t count_q, count_d;
    logic overflow_q, overflow_d;
    logic underflow_q, underflow_d;
    logic wr_accept, rd_accept;
    logic [ADDR_WIDTH-1:0] wr_addr, rd_addr;

    // Occupancy comes from count_q alone, so pointer MSBs only track wrap.
    logic unused_ptr_msb;
    assign unused_ptr_msb = wr_ptr_q[ADDR_WIDTH] ^ rd_ptr_q[ADDR_WIDTH];

    assign wr_addr = wr_ptr_q[ADDR_WIDTH-1:0];
    assign rd_addr = rd_ptr_q[ADDR_WIDTH-1:0];

    assign wr_full_o      = (count_q == DepthCnt);
    assign rd_empty_o     = (count_q == '0);
    assign almost_full_o  = (count_q >= AfCnt);
    assign almost_empty_o = (count_q <= AeCnt);
    assign count_o        = count_q;
    assign overflow_o     = overflow_q;
    assign underflow_o    = underflow_q;

    assign wr_accept = wr_en_i && !wr_full_o;
    assign rd_accept = rd_en_i && !rd_empty_o;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        if (wr_accept) wr_ptr_d = wr_ptr_q + cnt_t'(1);
        if (rd_accept) rd_ptr_d = rd_ptr_q + cnt_t'(1);

        unique case ({wr_accept, rd_accept})
            2'b10:   count_d = count_q + cnt_t'(1);
            2'b01:   count_d = count_q - cnt_t'(1);
            default: count_d = count_q;
        endcase

        // Set conditions are applied last so they win over clr_err_i.
        if (clr_err_i) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
        if (wr_en_i && wr_full_o)  overflow_d  = 1'b1;
        if (rd_en_i && rd_empty_o) underflow_d = 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_accept) mem_q[wr_addr] <= data_in_i;
    end

    if (FWFT) begin : g_fwft
        // Head word is shown directly; forced to zero while empty so reset reads 0.
        assign data_out_o = rd_empty_o ? '0 : mem_q[rd_addr];
    end else begin : g_std
        logic [DATA_WIDTH-1:0] dout_q;

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                dout_q <= '0;
            end else if (rd_accept) begin
                dout_q <= mem_q[rd_addr];
            end
        end

        assign data_out_o = dout_q;
    end

endmodule
